// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, default widths and timer sizing for the UART TX scheduler.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, POP, LOAD, START, DRAIN, GAP} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_ACK_TIMEOUT = 15;
  localparam int DEF_GAP_CYCLES = 0;
  function automatic int timer_w(input int a, input int b);
    int m;
    m = a > b ? a : b;
    return m > 0 ? $clog2(m + 1) : 1;
  endfunction
endpackage

// File: rtl/uart_cycle_timer.sv
// uart_cycle_timer: loadable down-counter with a done flag at zero.
module uart_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !done) cnt <= cnt - 1'b1;
  assign done = (cnt == '0);
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: pops the TX FIFO one word at a time, hands it to the transmitter
// over a start/busy handshake and enforces an inter-frame gap.
module uart_tx_sched import uart_pkg::*; #(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             tx_start,
  output logic [WIDTH-1:0] tx_data,
  input  logic             tx_busy,
  output logic             sched_busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err,
  input  logic             err_clr
);
  localparam int TW = timer_w(ACK_TIMEOUT, GAP_CYCLES);
  localparam logic [TW-1:0] ACK_LD = TW'(ACK_TIMEOUT);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  localparam state_t POST = GAP_CYCLES > 0 ? GAP : IDLE;
  state_t state;
  logic t_load, t_dec, t_done;
  logic [TW-1:0] t_val;
  assign sched_busy = state != IDLE;
  // One timer serves both the ack timeout (START) and the gap (GAP); they never overlap.
  assign t_load = state == LOAD || (!tx_busy && (state == DRAIN || (state == START && t_done)));
  assign t_val = state == LOAD ? ACK_LD : GAP_LD;
  assign t_dec = state == START || state == GAP;
  uart_cycle_timer #(.W(TW)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(t_load), .load_val(t_val), .dec(t_dec), .done(t_done)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fifo_rd_en <= 1'b0;
      tx_start <= 1'b0;
      tx_data <= '0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
      err <= 1'b0;
    end else begin
      fifo_rd_en <= 1'b0;
      frame_done <= 1'b0;
      if (err_clr) err <= 1'b0;
      case (state)
        IDLE: if (en && !fifo_empty && !tx_busy) begin
          fifo_rd_en <= 1'b1;
          state <= POP;
        end
        POP: state <= LOAD;
        LOAD: begin
          tx_data <= fifo_rd_data;
          tx_start <= 1'b1;
          state <= START;
        end
        START: if (tx_busy) begin
          tx_start <= 1'b0;
          state <= DRAIN;
        end else if (t_done) begin
          tx_start <= 1'b0;
          err <= 1'b1;
          state <= POST;
        end
        DRAIN: if (!tx_busy) begin
          frame_done <= 1'b1;
          frame_cnt <= frame_cnt + 1'b1;
          state <= POST;
        end
        GAP: if (t_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
